// File: rtl/spi_slave_responder_pkg.sv
// -----------------------------------------------------------------------------
// spi_slave_responder_pkg
//   Shared constants for the SPI mode-0 responder: FSM state encodings and the
//   default filler byte sent on MISO when the local side has nothing queued.
// -----------------------------------------------------------------------------
package spi_slave_responder_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_WAIT_HIGH = 2'd0;
  localparam logic [1:0] ST_IDLE      = 2'd1;
  localparam logic [1:0] ST_ACTIVE    = 2'd2;

  // Byte shifted out when no TX byte is available at a byte boundary
  localparam logic [7:0] DEFAULT_IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/spi_slave_responder_sync_bit.sv
// -----------------------------------------------------------------------------
// spi_slave_responder_sync_bit
//   STAGES-deep flip-flop chain bringing one asynchronous pin into clk.
//   Ports: clk, rst_n (async active-low), d (async input), q (synchronised).
//   RST_VAL sets the level the whole chain takes during reset, so the output
//   looks like the pin's idle level until real samples have propagated.
// -----------------------------------------------------------------------------
module spi_slave_responder_sync_bit #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_r;

  // Shift the pin sample through the synchroniser chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_r <= {STAGES{RST_VAL}};
    end else begin
      chain_r <= {chain_r[STAGES-2:0], d};
    end
  end

  assign q = chain_r[STAGES-1];

endmodule

// File: rtl/spi_slave_responder.sv
// -----------------------------------------------------------------------------
// spi_slave_responder
//   SPI mode-0 (CPOL=0, CPHA=0) slave, oversampled in the clk domain.
//   Ports:
//     clk, rst_n            system clock, async active-low reset
//     spi_clk/spi_cs_n/spi_mosi  SPI pins from the master (asynchronous)
//     spi_miso, spi_miso_oe MISO data and its output enable (tristate built above)
//     tx_data/tx_valid/tx_ready  one-byte TX holding register, valid/ready handshake
//     rx_data/rx_valid      last received byte and its 1-clk update strobe
//     tx_underrun           1-clk strobe: IDLE_BYTE substituted at a byte boundary
//     frame_start/frame_end 1-clk strobes on CS assert / deassert
//     busy                  high while a frame is active
//     byte_count            completed bytes in the current/last frame (saturating)
// -----------------------------------------------------------------------------
module spi_slave_responder
  import spi_slave_responder_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = DEFAULT_IDLE_BYTE,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spi_clk,
  input  logic             spi_cs_n,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic             spi_miso_oe,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             tx_underrun,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy,
  output logic [CNT_W-1:0] byte_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  logic cs_sync_s, sclk_sync_s, mosi_sync_s;
  logic cs_prev_r, sclk_prev_r;
  logic [SYNC_STAGES-1:0] primed_r;
  logic [1:0] state_r;
  logic [3:0] bit_cnt_r;
  logic [7:0] rx_shift_r, tx_shift_r, hold_data_r, rx_data_r;
  logic tx_ready_r, rx_valid_r, tx_underrun_r, frame_start_r, frame_end_r;
  logic miso_oe_r, busy_r;
  logic [CNT_W-1:0] byte_count_r;

  spi_slave_responder_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(spi_cs_n), .q(cs_sync_s));
  spi_slave_responder_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(spi_clk), .q(sclk_sync_s));
  spi_slave_responder_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(spi_mosi), .q(mosi_sync_s));

  logic sclk_rise_s, sclk_fall_s, cs_fall_s, cs_rise_s, active_s, enter_s;
  logic byte_last_s, reload_s, consume_s, accept_s;
  logic [7:0] load_byte_s;

  assign sclk_rise_s = sclk_sync_s & ~sclk_prev_r;
  assign sclk_fall_s = ~sclk_sync_s & sclk_prev_r;
  assign cs_fall_s   = ~cs_sync_s & cs_prev_r;
  assign cs_rise_s   = cs_sync_s & ~cs_prev_r;
  assign active_s    = (state_r == ST_ACTIVE);
  assign enter_s     = (state_r == ST_IDLE) & cs_fall_s;
  // The 8th rise still completes the byte even when CS rises in the same clk
  assign byte_last_s = active_s & sclk_rise_s & (bit_cnt_r == 4'd7);
  assign reload_s    = active_s & ~cs_rise_s & sclk_fall_s & (bit_cnt_r == 4'd8);
  assign consume_s   = enter_s | reload_s;
  assign accept_s    = tx_valid & tx_ready_r;
  assign load_byte_s = tx_ready_r ? IDLE_BYTE : hold_data_r;

  // Edge-detect history and synchroniser priming after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_prev_r   <= 1'b1;
      sclk_prev_r <= 1'b0;
      primed_r    <= {SYNC_STAGES{1'b0}};
    end else begin
      cs_prev_r   <= cs_sync_s;
      sclk_prev_r <= sclk_sync_s;
      primed_r    <= {primed_r[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Frame FSM with its strobes; WAIT_HIGH ignores a frame already running at
  // reset release, and only trusts cs once the synchroniser holds real samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_WAIT_HIGH;
      frame_start_r <= 1'b0;
      frame_end_r   <= 1'b0;
      miso_oe_r     <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      frame_start_r <= 1'b0;
      frame_end_r   <= 1'b0;
      case (state_r)
        ST_WAIT_HIGH: begin
          if (primed_r[SYNC_STAGES-1] && cs_sync_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_WAIT_HIGH;
          end
        end
        ST_IDLE: begin
          if (cs_fall_s) begin
            state_r       <= ST_ACTIVE;
            frame_start_r <= 1'b1;
            miso_oe_r     <= 1'b1;
            busy_r        <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACTIVE: begin
          if (cs_rise_s) begin
            state_r     <= ST_IDLE;
            frame_end_r <= 1'b1;
            miso_oe_r   <= 1'b0;
            busy_r      <= 1'b0;
          end else begin
            state_r <= ST_ACTIVE;
          end
        end
        default: begin
          state_r   <= ST_WAIT_HIGH;
          miso_oe_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  // Bit counter, receive shifter, received byte and byte counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r    <= 4'd0;
      rx_shift_r   <= 8'h00;
      rx_data_r    <= 8'h00;
      rx_valid_r   <= 1'b0;
      byte_count_r <= {CNT_W{1'b0}};
    end else begin
      rx_valid_r <= byte_last_s;
      if (enter_s) begin
        bit_cnt_r    <= 4'd0;
        byte_count_r <= {CNT_W{1'b0}};
      end else if (active_s) begin
        if (sclk_rise_s) begin
          rx_shift_r <= {rx_shift_r[6:0], mosi_sync_s};
        end
        if (byte_last_s) begin
          rx_data_r    <= {rx_shift_r[6:0], mosi_sync_s};
          byte_count_r <= sat_inc(byte_count_r);
        end
        // A partial byte at CS rise is simply dropped by clearing the count
        if (cs_rise_s) begin
          bit_cnt_r <= 4'd0;
        end else if (sclk_rise_s) begin
          bit_cnt_r <= bit_cnt_r + 4'd1;
        end else if (reload_s) begin
          bit_cnt_r <= 4'd0;
        end else begin
          bit_cnt_r <= bit_cnt_r;
        end
      end else begin
        bit_cnt_r <= 4'd0;
      end
    end
  end

  // Transmit shifter and one-byte holding register; consumption empties the
  // holder, and a write arriving while it is empty is taken after that
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift_r    <= 8'h00;
      hold_data_r   <= 8'h00;
      tx_ready_r    <= 1'b1;
      tx_underrun_r <= 1'b0;
    end else begin
      tx_underrun_r <= consume_s & tx_ready_r;
      if (consume_s) begin
        tx_shift_r <= load_byte_s;
      end else if (active_s && !cs_rise_s && sclk_fall_s) begin
        tx_shift_r <= {tx_shift_r[6:0], 1'b0};
      end else begin
        tx_shift_r <= tx_shift_r;
      end
      if (accept_s) begin
        hold_data_r <= tx_data;
        tx_ready_r  <= 1'b0;
      end else if (consume_s) begin
        tx_ready_r <= 1'b1;
      end else begin
        tx_ready_r <= tx_ready_r;
      end
    end
  end

  assign spi_miso    = tx_shift_r[7];
  assign spi_miso_oe = miso_oe_r;
  assign tx_ready    = tx_ready_r;
  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign tx_underrun = tx_underrun_r;
  assign frame_start = frame_start_r;
  assign frame_end   = frame_end_r;
  assign busy        = busy_r;
  assign byte_count  = byte_count_r;

endmodule

// File: tb/tb_spi_slave_responder.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_responder
//   Directed bench: a mode-0 SPI master model drives the pins, a feeder
//   process serves tx_data from a byte list, and a monitor logs strobes.
// -----------------------------------------------------------------------------
module tb_spi_slave_responder;

  logic        clk = 1'b0;
  logic        rst_n, spi_clk, spi_cs_n, spi_mosi;
  logic        spi_miso, spi_miso_oe, tx_valid, tx_ready, rx_valid;
  logic        tx_underrun, frame_start, frame_end, busy;
  logic [7:0]  tx_data, rx_data;
  logic [15:0] byte_count;

  always #5 clk = ~clk;

  spi_slave_responder dut (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
    .frame_start(frame_start), .frame_end(frame_end), .busy(busy),
    .byte_count(byte_count));

  int pass_cnt = 0;
  int total_cnt = 0;
  int half_clk = 10;

  logic [7:0] rx_log [0:1023];
  int rx_cnt = 0, fs_cnt = 0, fe_cnt = 0, ur_cnt = 0;

  logic [7:0] tx_buf [0:511];
  int tx_wr = 0, tx_rd = 0;

  // Monitor: log strobes at the falling clk edge
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid === 1'b1) begin
        if (rx_cnt < 1024) rx_log[rx_cnt] = rx_data;
        rx_cnt++;
      end
      if (frame_start === 1'b1) fs_cnt++;
      if (frame_end === 1'b1) fe_cnt++;
      if (tx_underrun === 1'b1) ur_cnt++;
    end
  end

  // Feeder: offer tx_buf entries in order, advancing on each handshake
  initial begin
    bit acc;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    forever begin
      @(negedge clk);
      acc = (tx_valid === 1'b1) && (tx_ready === 1'b1);
      @(posedge clk);
      #1;
      if (acc) tx_rd++;
      tx_valid = (tx_rd < tx_wr);
      tx_data  = (tx_rd < tx_wr) ? tx_buf[tx_rd] : 8'h00;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Shift nbits MSB-first; MISO is sampled at each rising SCLK edge
  task automatic spi_bits(input logic [7:0] m, input int nbits, input bit last_fall,
                          output logic [7:0] s);
    s = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = m[7-i];
      wait_clk(half_clk);
      spi_clk = 1'b1;
      s[7-i] = spi_miso;
      wait_clk(half_clk);
      if (i < nbits - 1 || last_fall) spi_clk = 1'b0;
    end
  endtask

  task automatic cs_high();
    wait_clk(half_clk);
    spi_cs_n = 1'b1;
    wait_clk(4 * half_clk);
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_buf[tx_wr] = b;
    tx_wr++;
  endtask

  task automatic wait_loaded(input string name);
    int k = 0;
    while (tx_ready !== 1'b0 && k < 100) begin
      wait_clk(1);
      k++;
    end
    total_cnt++;
    if (tx_ready !== 1'b0) $display("FAIL %s_hold_load: tx_ready=%b want 0", name, tx_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; spi_clk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    wait_clk(4);
    @(negedge clk);
    total_cnt++;
    if ({spi_miso, spi_miso_oe, busy} !== 3'b000)
      $display("FAIL rst_pins: miso/oe/busy=%b want 000", {spi_miso, spi_miso_oe, busy});
    else pass_cnt++;
    total_cnt++;
    if (tx_ready !== 1'b1) $display("FAIL rst_tx_ready: got %b want 1", tx_ready);
    else pass_cnt++;
    total_cnt++;
    if ({rx_valid, tx_underrun, frame_start, frame_end} !== 4'b0000)
      $display("FAIL rst_strobes: got %b want 0000", {rx_valid, tx_underrun, frame_start, frame_end});
    else pass_cnt++;
    total_cnt++;
    if (rx_data !== 8'h00 || byte_count !== 16'd0)
      $display("FAIL rst_rx: rx_data=%h byte_count=%0d want 00/0", rx_data, byte_count);
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_clk(10);
  endtask

  task automatic test_single_byte();
    logic [7:0] s;
    int rb, fsb, feb;
    push_tx(8'hDE);
    wait_loaded("t1");
    rb = rx_cnt; fsb = fs_cnt; feb = fe_cnt;
    spi_cs_n = 1'b0;
    spi_bits(8'hA5, 8, 1'b1, s);
    total_cnt++;
    if (busy !== 1'b1 || spi_miso_oe !== 1'b1)
      $display("FAIL t1_busy: busy=%b oe=%b want 1/1", busy, spi_miso_oe);
    else pass_cnt++;
    cs_high();
    total_cnt++;
    if (s !== 8'hDE) $display("FAIL t1_miso: got %h want de", s);
    else pass_cnt++;
    total_cnt++;
    if (rx_cnt - rb != 1 || rx_log[rb] !== 8'hA5)
      $display("FAIL t1_rx: count=%0d first=%h want 1/a5", rx_cnt - rb, rx_log[rb]);
    else pass_cnt++;
    total_cnt++;
    if (fs_cnt - fsb != 1 || fe_cnt - feb != 1)
      $display("FAIL t1_frame: start=%0d end=%0d want 1/1", fs_cnt - fsb, fe_cnt - feb);
    else pass_cnt++;
    total_cnt++;
    if (byte_count !== 16'd1 || rx_data !== 8'hA5)
      $display("FAIL t1_count: byte_count=%0d rx_data=%h want 1/a5", byte_count, rx_data);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0 || spi_miso_oe !== 1'b0)
      $display("FAIL t1_idle: busy=%b oe=%b want 0/0", busy, spi_miso_oe);
    else pass_cnt++;
  endtask

  task automatic test_multi_byte();
    logic [7:0] mo [3];
    logic [7:0] exp_s [3];
    logic [7:0] s;
    int rb, bad;
    mo    = '{8'hDE, 8'hAD, 8'hBE};
    exp_s = '{8'hAA, 8'hBB, 8'hCC};
    push_tx(8'hAA); push_tx(8'hBB); push_tx(8'hCC);
    wait_loaded("t2");
    rb = rx_cnt;
    bad = 0;
    spi_cs_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      spi_bits(mo[i], 8, 1'b1, s);
      total_cnt++;
      if (s !== exp_s[i]) $display("FAIL t2_miso%0d: got %h want %h", i, s, exp_s[i]);
      else pass_cnt++;
    end
    cs_high();
    for (int i = 0; i < 3; i++) if (rx_log[rb + i] !== mo[i]) bad++;
    total_cnt++;
    if (rx_cnt - rb != 3 || bad != 0)
      $display("FAIL t2_rx: count=%0d wrong=%0d want 3/0", rx_cnt - rb, bad);
    else pass_cnt++;
    total_cnt++;
    if (byte_count !== 16'd3) $display("FAIL t2_count: got %0d want 3", byte_count);
    else pass_cnt++;
  endtask

  task automatic test_underrun();
    logic [7:0] s0, s1;
    int rb, ub;
    total_cnt++;
    if (tx_ready !== 1'b1) $display("FAIL t3_empty: tx_ready=%b want 1", tx_ready);
    else pass_cnt++;
    rb = rx_cnt; ub = ur_cnt;
    spi_cs_n = 1'b0;
    spi_bits(8'h12, 8, 1'b1, s0);
    spi_bits(8'h34, 8, 1'b0, s1);
    // Count only the underruns for the two clocked-out bytes, before the
    // trailing SCLK fall preloads a byte that is never shifted
    wait_clk(half_clk);
    total_cnt++;
    if (ur_cnt - ub != 2) $display("FAIL t3_underrun: got %0d want 2", ur_cnt - ub);
    else pass_cnt++;
    spi_clk = 1'b0;
    cs_high();
    total_cnt++;
    if (s0 !== 8'hFF || s1 !== 8'hFF) $display("FAIL t3_miso: got %h %h want ff ff", s0, s1);
    else pass_cnt++;
    total_cnt++;
    if (rx_cnt - rb != 2 || rx_log[rb] !== 8'h12 || rx_log[rb + 1] !== 8'h34)
      $display("FAIL t3_rx: count=%0d bytes=%h %h want 2 12 34", rx_cnt - rb, rx_log[rb], rx_log[rb + 1]);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    logic [7:0] s;
    int rb, feb;
    rb = rx_cnt; feb = fe_cnt;
    spi_cs_n = 1'b0;
    spi_bits(8'hF0, 5, 1'b1, s);
    cs_high();
    total_cnt++;
    if (rx_cnt - rb != 0 || fe_cnt - feb != 1)
      $display("FAIL t4_abort: rx=%0d frame_end=%0d want 0/1", rx_cnt - rb, fe_cnt - feb);
    else pass_cnt++;
    spi_cs_n = 1'b0;
    spi_bits(8'h3C, 8, 1'b1, s);
    cs_high();
    total_cnt++;
    if (rx_cnt - rb != 1 || rx_data !== 8'h3C || byte_count !== 16'd1)
      $display("FAIL t4_realign: rx=%0d rx_data=%h byte_count=%0d want 1/3c/1", rx_cnt - rb, rx_data, byte_count);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] s;
    int rb, fsb;
    spi_cs_n = 1'b0;
    spi_bits(8'h81, 3, 1'b1, s);
    rst_n = 1'b0;
    wait_clk(3);
    @(negedge clk);
    total_cnt++;
    if ({spi_miso, spi_miso_oe, busy, tx_ready} !== 4'b0001)
      $display("FAIL t5_rst_pins: miso/oe/busy/ready=%b want 0001", {spi_miso, spi_miso_oe, busy, tx_ready});
    else pass_cnt++;
    total_cnt++;
    if (rx_data !== 8'h00 || byte_count !== 16'd0)
      $display("FAIL t5_rst_rx: rx_data=%h byte_count=%0d want 00/0", rx_data, byte_count);
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rb = rx_cnt; fsb = fs_cnt;
    spi_bits(8'hFF, 8, 1'b1, s);
    spi_bits(8'h00, 5, 1'b1, s);
    total_cnt++;
    if (rx_cnt - rb != 0 || fs_cnt - fsb != 0 || busy !== 1'b0)
      $display("FAIL t5_ignored: rx=%0d start=%0d busy=%b want 0/0/0", rx_cnt - rb, fs_cnt - fsb, busy);
    else pass_cnt++;
    cs_high();
    spi_cs_n = 1'b0;
    spi_bits(8'h5A, 8, 1'b1, s);
    cs_high();
    total_cnt++;
    if (rx_cnt - rb != 1 || rx_data !== 8'h5A)
      $display("FAIL t5_after: rx=%0d rx_data=%h want 1/5a", rx_cnt - rb, rx_data);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] s, b;
    int rb, ub, miso_bad, rx_bad;
    half_clk = 4;
    for (int i = 0; i < 256; i++) begin
      b = i[7:0];
      push_tx(~b);
    end
    wait_loaded("t6");
    rb = rx_cnt; ub = ur_cnt;
    miso_bad = 0; rx_bad = 0;
    spi_cs_n = 1'b0;
    for (int i = 0; i < 256; i++) begin
      b = i[7:0];
      spi_bits(b, 8, (i != 255), s);
      if (s !== ~b) miso_bad++;
    end
    wait_clk(half_clk);
    total_cnt++;
    if (ur_cnt - ub != 0) $display("FAIL t6_underrun: got %0d want 0", ur_cnt - ub);
    else pass_cnt++;
    spi_clk = 1'b0;
    cs_high();
    for (int i = 0; i < 256; i++) begin
      b = i[7:0];
      if (rx_log[rb + i] !== b) rx_bad++;
    end
    total_cnt++;
    if (miso_bad != 0) $display("FAIL t6_miso: %0d wrong bytes want 0", miso_bad);
    else pass_cnt++;
    total_cnt++;
    if (rx_cnt - rb != 256 || rx_bad != 0)
      $display("FAIL t6_rx: count=%0d wrong=%0d want 256/0", rx_cnt - rb, rx_bad);
    else pass_cnt++;
    total_cnt++;
    if (byte_count !== 16'd256) $display("FAIL t6_count: got %0d want 256", byte_count);
    else pass_cnt++;
    half_clk = 10;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_multi_byte();
    test_underrun();
    test_abort();
    test_reset_mid_frame();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
